// File: rtl/fetch_pkg.sv
// Shared defaults and state encoding for the instruction fetch unit.
package fetch_pkg;

  localparam int unsigned ADDR_W_DEF = 3;
  localparam int unsigned INST_W_DEF = 8;

  localparam logic [7:0] HALT_OPCODE_DEF = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch: PC, memory address mux and valid/ready output stage.
// Optional halt-on-opcode behaviour is enabled with FETCH_HALT_EN.
module inst_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned INST_W = INST_W_DEF
`ifdef FETCH_HALT_EN
  , parameter logic [INST_W-1:0] HALT_OPCODE = INST_W'(HALT_OPCODE_DEF)
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc,
  output logic              halted
);

  fetch_state_t      state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic [ADDR_W-1:0] out_pc_nxt;
  logic              valid_nxt;
  logic              stall_c;
  logic              issue_c;
  logic [ADDR_W-1:0] addr_c;

  assign stall_c   = out_valid && !out_ready;
  assign imem_addr = addr_c;
  assign out_inst  = imem_inst;

  // Redirect wins; a stall re-reads the held word so out_inst stays stable.
  always_comb begin
    addr_c = pc;
    if (redirect_valid) begin
      addr_c = redirect_addr;
    end else if (stall_c) begin
      addr_c = out_pc;
    end
  end

`ifdef FETCH_HALT_EN
  logic halt_xfer_c;
  assign halt_xfer_c = out_valid && out_ready && (imem_inst == HALT_OPCODE);
  assign halted      = (state == HALT);
`else
  assign halted      = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    valid_nxt  = out_valid;
    out_pc_nxt = out_pc;
    issue_c    = 1'b0;

    case (state)
      IDLE: begin
        valid_nxt = 1'b0;
        if (en) begin
          issue_c   = 1'b1;
          state_nxt = RUN;
        end else if (redirect_valid) begin
          pc_nxt = redirect_addr;
        end
      end
      RUN: begin
        if (redirect_valid) begin
          issue_c = 1'b1;
`ifdef FETCH_HALT_EN
        end else if (halt_xfer_c) begin
          state_nxt = HALT;
          valid_nxt = 1'b0;
`endif
        end else if (stall_c) begin
          // hold pc, out_pc and out_valid until the word is taken
        end else if (en) begin
          issue_c = 1'b1;
        end else begin
          state_nxt = IDLE;
          valid_nxt = 1'b0;
        end
      end
`ifdef FETCH_HALT_EN
      HALT: begin
        valid_nxt = 1'b0;
        if (redirect_valid) begin
          issue_c   = 1'b1;
          state_nxt = RUN;
        end
      end
`endif
      default: begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
      end
    endcase

    // Issue: the word addressed now is presented next cycle.
    if (issue_c) begin
      valid_nxt  = 1'b1;
      out_pc_nxt = addr_c;
      pc_nxt     = addr_c + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= '0;
      out_valid <= 1'b0;
      out_pc    <= '0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      out_valid <= valid_nxt;
      out_pc    <= out_pc_nxt;
    end
  end

endmodule
